// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline-boundary register with a one-entry skid buffer.
// Carries a control vector (zeroed on bubbles) and an ungated data payload
// across a valid/ready handshake.
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high. Valid must not depend on ready. in_ready is derived only from
// flop state, so there is no combinational path from out_ready to in_ready.
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main register drives the outputs directly; the skid register catches
    // the one entry accepted while main is stalled.
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic main_free;

    // Skid empty means there is room for one more entry.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && !skid_valid;
    // Main can take a new entry this cycle if empty or being delivered.
    assign main_free = !main_valid || out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    // Main register: refill from skid first (oldest), else from input, else
    // go empty with control cleared so bubbles never carry strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end
    end

    // Skid register: loads only when main is held and an entry is accepted;
    // drains into main as soon as main frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles where the presented entry is not taken;
    // only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, skid fill, flush,
// bubble control gating and the stall counter (when compiled in).
module tb_pipe_stage_skid;

    localparam int CTRL_W = 2;
    localparam int DATA_W = 69;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; return 1 time unit after it so outputs are settled.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input int exp_en);
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk(tag, 128'(stall_cnt), 128'(exp_en));
`else
        chk(tag, 128'(stall_cnt), 128'(0));
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_ctrl"}, 128'(out_ctrl), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    task automatic present(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset asserted mid-cycle clears outputs immediately.
        #3 rst = 1'b1;
        #1;
        chk_idle("reset");
        chk("reset_out_data", 128'(out_data), 128'(0));
        chk_stall("reset_stall", 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk_idle("post_reset");

        // Streaming: 8 back-to-back entries, out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            present(2'b11, DATA_W'(i));
            cycle();
            chk($sformatf("stream%0d_valid", i), 128'(out_valid), 128'(1));
            chk($sformatf("stream%0d_data", i), 128'(out_data), 128'(i));
            chk($sformatf("stream%0d_ctrl", i), 128'(out_ctrl), 128'(3));
            chk($sformatf("stream%0d_in_ready", i), 128'(in_ready), 128'(1));
        end
        in_valid = 1'b0;
        cycle();
        chk_idle("stream_drain");

        // Skid fill: A enters main, B goes to skid, C is held off.
        present(2'b01, 69'hA);
        out_ready = 1'b0;
        cycle();
        chk("skid_A_data", 128'(out_data), 128'hA);
        chk("skid_A_in_ready", 128'(in_ready), 128'(1));
        present(2'b10, 69'hB);
        cycle();
        chk("skid_B_out_data", 128'(out_data), 128'hA);
        chk("skid_B_in_ready", 128'(in_ready), 128'(0));
        present(2'b11, 69'hC);
        cycle();
        chk("skid_C_hold_data", 128'(out_data), 128'hA);
        chk("skid_C_hold_ctrl", 128'(out_ctrl), 128'(1));
        chk("skid_C_in_ready", 128'(in_ready), 128'(0));
        cycle();
        chk("skid_C_hold2_data", 128'(out_data), 128'hA);
        chk_stall("skid_stall", 3);
        out_ready = 1'b1;
        cycle();
        chk("drain_B_data", 128'(out_data), 128'hB);
        chk("drain_B_ctrl", 128'(out_ctrl), 128'(2));
        chk("drain_B_in_ready", 128'(in_ready), 128'(1));
        cycle();
        chk("drain_C_data", 128'(out_data), 128'hC);
        chk("drain_C_ctrl", 128'(out_ctrl), 128'(3));
        in_valid = 1'b0;
        cycle();
        chk_idle("drain_done");

        // Flush with main and skid full; D presented in the flush cycle.
        out_ready = 1'b0;
        present(2'b10, 69'hAA);
        cycle();
        present(2'b11, 69'hBB);
        cycle();
        chk("pre_flush_in_ready", 128'(in_ready), 128'(0));
        chk("pre_flush_data", 128'(out_data), 128'hAA);
        present(2'b11, 69'hDD);
        flush = 1'b1;
        cycle();
        chk_idle("flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("post_flush%0d_valid", i), 128'(out_valid), 128'(0));
        end
        chk_stall("flush_stall", 5);

        // Bubble control: in_ctrl=11 with in_valid low must not leak.
        in_valid = 1'b0;
        in_ctrl  = 2'b11;
        in_data  = 69'h1F;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("bubble%0d_ctrl", i), 128'(out_ctrl), 128'(0));
            chk($sformatf("bubble%0d_valid", i), 128'(out_valid), 128'(0));
        end

        // Long stall: counter saturates at 15, survives flush, clears on reset.
        out_ready = 1'b0;
        present(2'b01, 69'hE);
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("stall_hold_data", 128'(out_data), 128'hE);
        chk("stall_hold_valid", 128'(out_valid), 128'(1));
        chk("stall_in_ready", 128'(in_ready), 128'(1));
        chk_stall("stall_sat", 15);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk_idle("stall_flush");
        chk_stall("stall_after_flush", 15);

        // Reset mid-transfer with an entry held.
        present(2'b11, 69'hF);
        cycle();
        chk("rst_mid_valid_before", 128'(out_valid), 128'(1));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_out_data", 128'(out_data), 128'(0));
        chk_stall("rst_mid_stall", 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk_idle("rst_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
